// File: rtl/lock_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
// Shared definitions for the key-delivery front end of logic-locked HLS cores:
//   - lock_state_e : control FSM state encoding (also exported for debug)
//   - DEF_KEY_W / DEF_CHUNK_W : default key and chunk widths
//   - num_chunks() : ceil(key_w / chunk_w)
//   - cnt_width()  : chunk counter width, never narrower than one bit
// -----------------------------------------------------------------------------
package lock_pkg;

  localparam int DEF_KEY_W   = 3071;
  localparam int DEF_CHUNK_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_ARMED  = 3'd3,
    ST_ERROR  = 3'd4
  } lock_state_e;

  function automatic int num_chunks(input int key_w, input int chunk_w);
    return (key_w + chunk_w - 1) / chunk_w;
  endfunction

  // $clog2(1) is 0; a single-chunk key still needs a one-bit counter so
  // that the index compare stays well formed.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lock_key_loader_if.sv
// -----------------------------------------------------------------------------
// lock_key_loader_if
// Key chunk stream from the SoC provisioning path into lock_key_loader.
//   key_valid : chunk present on key_data          (master -> slave)
//   key_ready : loader accepts a chunk this cycle  (slave  -> master)
//   key_data  : CHUNK_W-bit key chunk, chunk 0 first
//   key_last  : marks the final chunk of a key
//   key_clear : synchronous pulse, discard key and error state
//
// Handshake: a chunk transfers on every rising ap_clk edge where
// key_valid & key_ready are both 1. The master holds key_data/key_last
// stable while key_valid is high and not yet accepted; key_ready may be
// low at any time and does not depend on key_valid. key_clear is not part
// of the handshake and takes effect on the edge it is sampled high.
// -----------------------------------------------------------------------------
interface lock_key_loader_if
  import lock_pkg::*;
#(
  parameter int CHUNK_W = DEF_CHUNK_W
);

  logic               key_valid;
  logic               key_ready;
  logic [CHUNK_W-1:0] key_data;
  logic               key_last;
  logic               key_clear;

  modport master (
    output key_valid,
    output key_data,
    output key_last,
    output key_clear,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_data,
    input  key_last,
    input  key_clear,
    output key_ready
  );

endinterface

// File: rtl/lock_key_shadow.sv
// -----------------------------------------------------------------------------
// lock_key_shadow
// Chunk-indexed shadow register that assembles a key before it is committed.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   clr_i    : synchronous clear of the whole shadow (wins over we_i)
//   we_i     : write data_i into chunk idx_i
//   idx_i    : chunk index, chunk i occupies bits [i*CHUNK_W +: CHUNK_W]
//   data_i   : chunk data
//   shadow_o : assembled KEY_W-bit key
// Bits of the final chunk that fall above KEY_W-1 are dropped.
// -----------------------------------------------------------------------------
module lock_key_shadow
  import lock_pkg::*;
#(
  parameter int KEY_W   = DEF_KEY_W,
  parameter int CHUNK_W = DEF_CHUNK_W
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic                                           clr_i,
  input  logic                                           we_i,
  input  logic [cnt_width(num_chunks(KEY_W, CHUNK_W))-1:0] idx_i,
  input  logic [CHUNK_W-1:0]                             data_i,
  output logic [KEY_W-1:0]                               shadow_o
);

  localparam int NUM_CHUNKS = num_chunks(KEY_W, CHUNK_W);
  localparam int CNT_W      = cnt_width(NUM_CHUNKS);
  // Width of the final, possibly partial, chunk.
  localparam int LAST_W     = KEY_W - (NUM_CHUNKS - 1) * CHUNK_W;

  logic [KEY_W-1:0] shadow_q;
  logic [KEY_W-1:0] shadow_d;

  // Each chunk slice is either overwritten or held; slices are disjoint,
  // so the final chunk simply uses its narrower width.
  for (genvar c = 0; c < NUM_CHUNKS; c++) begin : g_chunk
    localparam int W = (c == NUM_CHUNKS - 1) ? LAST_W : CHUNK_W;
    assign shadow_d[c*CHUNK_W +: W] =
      (we_i && (idx_i == CNT_W'(c))) ? data_i[W-1:0] : shadow_q[c*CHUNK_W +: W];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
    end else if (clr_i) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign shadow_o = shadow_q;

endmodule

// File: rtl/lock_key_loader.sv
// -----------------------------------------------------------------------------
// lock_key_loader
// Run-time key delivery for logic-locked HLS cores. Replaces a hard-wired
// working_key with a key streamed in as CHUNK_W-bit chunks. Chunks are
// assembled in a shadow register, framing is checked, and the key is copied
// to working_key only while the core reports idle. ap_start is gated until a
// committed key is armed.
//   ap_clk       : clock, rising edge
//   ap_rst_n     : asynchronous active-low reset
//   key_if       : chunk stream (valid/ready/data/last/clear), slave side
//   core_idle    : core ap_idle
//   ap_start_in  : start request from host
//   ap_start_out : gated start to the core
//   working_key  : committed key to the core
//   key_loaded   : a committed key is active
//   key_error    : framing error latched (cleared only by key_clear)
//   dbg_state    : current control FSM state
// -----------------------------------------------------------------------------
module lock_key_loader
  import lock_pkg::*;
#(
  parameter int KEY_W   = DEF_KEY_W,
  parameter int CHUNK_W = DEF_CHUNK_W
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  lock_key_loader_if.slave   key_if,
  input  logic               core_idle,
  input  logic               ap_start_in,
  output logic               ap_start_out,
  output logic [KEY_W-1:0]   working_key,
  output logic               key_loaded,
  output logic               key_error,
  output lock_state_e        dbg_state
);

  localparam int               NUM_CHUNKS = num_chunks(KEY_W, CHUNK_W);
  localparam int               CNT_W      = cnt_width(NUM_CHUNKS);
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_CHUNKS - 1);

  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] working_key_q, working_key_d;
  logic             key_loaded_q, key_loaded_d;

  logic             accept;
  logic             ready;
  logic [CNT_W-1:0] cur_idx;
  logic             is_final;
  logic             shadow_we;
  logic             shadow_clr;
  logic [KEY_W-1:0] shadow;

  // Ready is held low during reset even though the state already reads IDLE.
  assign ready  = ap_rst_n &&
                  ((state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_ARMED));
  assign accept = key_if.key_valid && ready;

  // A chunk accepted outside LOAD always starts a new key at index 0,
  // which is what lets a reload begin straight from ARMED.
  assign cur_idx  = (state_q == ST_LOAD) ? cnt_q : '0;
  assign is_final = (cur_idx == LAST_IDX);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    working_key_d = working_key_q;
    key_loaded_d  = key_loaded_q;
    shadow_we     = 1'b0;
    shadow_clr    = 1'b0;

    if (key_if.key_clear) begin
      // Clear beats everything, including a chunk accepted the same cycle.
      state_d       = ST_IDLE;
      cnt_d         = '0;
      working_key_d = '0;
      key_loaded_d  = 1'b0;
      shadow_clr    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_LOAD, ST_ARMED: begin
          if (accept) begin
            shadow_we = 1'b1;
            if (is_final && key_if.key_last) begin
              state_d = ST_COMMIT;
              cnt_d   = '0;
            end else if (is_final || key_if.key_last) begin
              // key_last early, or missing on the final chunk.
              state_d      = ST_ERROR;
              cnt_d        = '0;
              key_loaded_d = 1'b0;
              shadow_clr   = 1'b1;
            end else begin
              state_d = ST_LOAD;
              cnt_d   = cur_idx + CNT_W'(1);
            end
          end
        end
        ST_COMMIT: begin
          // The core's key may only change while the core is idle.
          if (core_idle) begin
            working_key_d = shadow;
            key_loaded_d  = 1'b1;
            state_d       = ST_ARMED;
          end
        end
        ST_ERROR: begin
          key_loaded_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      working_key_q <= '0;
      key_loaded_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      working_key_q <= working_key_d;
      key_loaded_q  <= key_loaded_d;
    end
  end

  lock_key_shadow #(
    .KEY_W   (KEY_W),
    .CHUNK_W (CHUNK_W)
  ) u_shadow (
    .clk_i    (ap_clk),
    .rst_ni   (ap_rst_n),
    .clr_i    (shadow_clr),
    .we_i     (shadow_we),
    .idx_i    (cur_idx),
    .data_i   (key_if.key_data),
    .shadow_o (shadow)
  );

  // During a reload key_loaded stays 1 but the state is not ARMED, so
  // starts are held off until the new key is in place.
  assign ap_start_out     = ap_start_in && key_loaded_q && (state_q == ST_ARMED);
  assign key_if.key_ready = ready;
  assign working_key      = working_key_q;
  assign key_loaded       = key_loaded_q;
  assign key_error        = (state_q == ST_ERROR);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_lock_key_loader.sv
module tb_lock_key_loader;
  import lock_pkg::*;

  localparam int KW = 70;
  localparam int CW = 32;

  localparam logic [KW-1:0] KEY_A = 70'h3F_22222222_11111111;
  localparam logic [KW-1:0] KEY_B = 70'h2A_55555555_AAAAAAAA;
  localparam logic [KW-1:0] KEY_C = 70'h15_0BADF00D_DEADBEEF;
  localparam logic [KW-1:0] KEY_T = 70'h3F_89ABCDEF_01234567;

  // ---------------- clock / reset ----------------
  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          core_idle = 1'b1;
  logic          ap_start_in = 1'b0;
  logic          ap_start_out;
  logic [KW-1:0] working_key;
  logic          key_loaded;
  logic          key_error;
  lock_state_e   dbg_state;

  always #5 ap_clk = ~ap_clk;

  lock_key_loader_if #(.CHUNK_W(CW)) kif ();

  lock_key_loader #(
    .KEY_W   (KW),
    .CHUNK_W (CW)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .key_if       (kif),
    .core_idle    (core_idle),
    .ap_start_in  (ap_start_in),
    .ap_start_out (ap_start_out),
    .working_key  (working_key),
    .key_loaded   (key_loaded),
    .key_error    (key_error),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int            total = 0;
  int            bad = 0;
  logic [KW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send_chunk(input logic [CW-1:0] d, input logic l);
    int n = 0;
    kif.key_valid = 1'b1;
    kif.key_data  = d;
    kif.key_last  = l;
    while (!kif.key_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("ready_timeout", kif.key_ready, 1);
    tick();
    kif.key_valid = 1'b0;
    kif.key_last  = 1'b0;
  endtask

  task automatic send_key(input logic [KW-1:0] k);
    logic [CW-1:0] top_chunk;
    top_chunk = '0;
    top_chunk[KW-2*CW-1:0] = k[KW-1:2*CW];
    exp_q.push_back(k);
    send_chunk(k[CW-1:0], 1'b0);
    send_chunk(k[2*CW-1:CW], 1'b0);
    send_chunk(top_chunk, 1'b1);
  endtask

  task automatic check_commit(input string tag);
    logic [KW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check(tag, working_key, e);
      check({tag, "_loaded"}, key_loaded, 1);
    end
  endtask

  task automatic do_clear();
    kif.key_clear = 1'b1;
    tick();
    kif.key_clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    logic v, c;

    kif.key_valid = 1'b0;
    kif.key_data  = '0;
    kif.key_last  = 1'b0;
    kif.key_clear = 1'b0;

    // Reset state
    ap_start_in = 1'b1;
    #12;
    check("rst_ready", kif.key_ready, 0);
    check("rst_key", working_key, 0);
    check("rst_loaded", key_loaded, 0);
    check("rst_error", key_error, 0);
    check("rst_start", ap_start_out, 0);
    ap_start_in = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    #1;
    check("idle_ready", kif.key_ready, 1);
    check("idle_state", dbg_state, ST_IDLE);

    // Basic load with core idle
    send_key(KEY_A);
    check("a_commit_state", dbg_state, ST_COMMIT);
    check("a_not_yet_loaded", key_loaded, 0);
    check("a_ready_low", kif.key_ready, 0);
    tick();
    check_commit("a_key");
    check("a_armed", dbg_state, ST_ARMED);
    ap_start_in = 1'b1;
    #1;
    check("a_start_on", ap_start_out, 1);
    ap_start_in = 1'b0;
    #1;
    check("a_start_off", ap_start_out, 0);
    tick();

    // Early key_last -> error
    send_chunk(32'h12345678, 1'b0);
    check("e1_reload_loaded", key_loaded, 1);
    send_chunk(32'h00000009, 1'b1);
    check("e1_error", key_error, 1);
    check("e1_ready", kif.key_ready, 0);
    check("e1_loaded", key_loaded, 0);
    check("e1_key_held", working_key, KEY_A);
    ap_start_in = 1'b1;
    #1;
    check("e1_start_gated", ap_start_out, 0);
    ap_start_in = 1'b0;
    tick();
    check("e1_sticky", key_error, 1);
    do_clear();
    check("clr_key", working_key, 0);
    check("clr_loaded", key_loaded, 0);
    check("clr_error", key_error, 0);
    check("clr_ready", kif.key_ready, 1);
    check("clr_state", dbg_state, ST_IDLE);

    // Reload while armed, core busy for 10 cycles
    send_key(KEY_A);
    tick();
    check_commit("r_first");
    core_idle = 1'b0;
    send_key(KEY_B);
    check("r_commit_state", dbg_state, ST_COMMIT);
    for (int i = 0; i < 10; i++) begin
      check("r_hold_key", working_key, KEY_A);
      check("r_hold_loaded", key_loaded, 1);
      tick();
    end
    core_idle = 1'b1;
    #1;
    check("r_before_edge", working_key, KEY_A);
    tick();
    check_commit("r_new_key");

    // Missing key_last on final chunk -> error; then padding bits ignored
    do_clear();
    send_chunk(32'h00000001, 1'b0);
    send_chunk(32'h00000002, 1'b0);
    send_chunk(32'h00000003, 1'b0);
    check("e2_error", key_error, 1);
    check("e2_state", dbg_state, ST_ERROR);
    do_clear();
    exp_q.push_back(KEY_T);
    send_chunk(32'h01234567, 1'b0);
    send_chunk(32'h89ABCDEF, 1'b0);
    send_chunk(32'hFFFFFFFF, 1'b1);
    tick();
    check_commit("pad_key");

    // Reset mid-load
    send_chunk(KEY_C[31:0], 1'b0);
    send_chunk(KEY_C[63:32], 1'b0);
    ap_start_in = 1'b1;
    ap_rst_n = 1'b0;
    #1;
    check("mr_key", working_key, 0);
    check("mr_loaded", key_loaded, 0);
    check("mr_error", key_error, 0);
    check("mr_ready", kif.key_ready, 0);
    check("mr_start", ap_start_out, 0);
    ap_start_in = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    #1;
    check("mr_state", dbg_state, ST_IDLE);
    send_key(KEY_C);
    tick();
    check_commit("mr_reload");

    // Random valid with clear coincident on accepts
    do_clear();
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      v = 1'($urandom_range(0, 1));
      c = v && ((cnt == 2) || ($urandom_range(0, 3) == 0));
      kif.key_valid = v;
      kif.key_data  = $urandom;
      kif.key_last  = 1'b0;
      kif.key_clear = c;
      tick();
      if (c) cnt = 0;
      else if (v) cnt++;
      check("rnd_state", dbg_state, (cnt == 0) ? ST_IDLE : ST_LOAD);
    end
    kif.key_valid = 1'b0;
    kif.key_clear = 1'b0;
    tick();
    check("rnd_no_commit_key", working_key, 0);
    check("rnd_no_commit_loaded", key_loaded, 0);
    check("rnd_no_error", key_error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
